// File: rtl/switch_common_pkg.sv
// ---------------------------------------------------------------------------
// switch_common_pkg
// Shared constants and helpers for the switch datapath FIFOs.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package switch_common_pkg;

  localparam int PKT_FIFO_DEFAULT_WIDTH = 8;
  // One 1518-byte frame plus margin.
  localparam int PKT_FIFO_DEFAULT_DEPTH = 2048;
  localparam int STAT_COUNT_WIDTH       = 16;

  // Difference of two wrapped pointers, reduced modulo 2**bits.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned bits);
    logic [31:0] mask;
    mask = (32'd1 << bits) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/packet_fifo_if.sv
// ---------------------------------------------------------------------------
// packet_fifo_if
// Write/read handshake and status bundle of the packet FIFO.
// master: writer/reader side, slave: the FIFO.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface packet_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] write_data;
  logic             write_enable;
  logic             write_last;
  logic             write_drop;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             read_last;
  logic             is_empty;
  logic             is_full;
  logic             almost_full;
  logic [AW:0]      fill_level;
  logic [AW:0]      packet_count;

  modport master (
    output write_data, write_enable, write_last, write_drop, read_enable,
    input  read_data, read_valid, read_last, is_empty, is_full, almost_full,
           fill_level, packet_count
  );

  modport slave (
    input  write_data, write_enable, write_last, write_drop, read_enable,
    output read_data, read_valid, read_last, is_empty, is_full, almost_full,
           fill_level, packet_count
  );

endinterface

`default_nettype wire

// File: rtl/packet_fifo_ram.sv
// ---------------------------------------------------------------------------
// packet_fifo_ram
// Simple dual-port RAM, synchronous write, registered read. Also exposes the
// "last" flag (top bit) at the read address combinationally so the FIFO can
// account for packet ends in the cycle a read is accepted.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module packet_fifo_ram #(
  parameter int DW    = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  input  wire logic          wr_en,
  input  wire logic [AW-1:0] wr_addr,
  input  wire logic [DW-1:0] wr_data,
  input  wire logic          rd_en,
  input  wire logic [AW-1:0] rd_addr,
  output logic      [DW-1:0] rd_data,
  output logic               peek_last
);

  logic [DW-1:0] mem [DEPTH];

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; holds its value when no read is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  assign peek_last = mem[rd_addr][DW-1];

endmodule

`default_nettype wire

// File: rtl/packet_fifo.sv
// ---------------------------------------------------------------------------
// packet_fifo
// Store-and-forward packet FIFO. Words are written speculatively and become
// visible to the reader only when the packet's last word commits. A drop,
// or a packet that overflowed, rewinds the write pointer to the last commit.
// Optional statistics: define PACKET_FIFO_STATS_EN to add drop_count and
// overflow_seen outputs.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module packet_fifo
  import switch_common_pkg::*;
#(
  parameter int WIDTH              = PKT_FIFO_DEFAULT_WIDTH,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  wire logic   clock,
  input  wire logic   reset_n,
  packet_fifo_if.slave bus
`ifdef PACKET_FIFO_STATS_EN
  ,
  output logic [STAT_COUNT_WIDTH-1:0] drop_count,
  output logic                        overflow_seen
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          PW       = AW + 1;
  localparam logic [AW:0] DEPTH_W  = PW'(DEPTH);
  localparam logic [AW:0] MARGIN_W = PW'(ALMOST_FULL_MARGIN);

  logic [AW:0]  wr_ptr, commit_ptr, rd_ptr, packet_count_q, fill;
  logic         overflow, read_valid_q;
  logic         full, empty, wr_accept, lost, rewind, commit;
  logic         rd_accept, rd_is_last, pkt_dec;
  logic [WIDTH:0] rd_word;

  // Flags and per-cycle control decisions from the registered pointers.
  always_comb begin
    fill      = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    full      = (fill == DEPTH_W);
    empty     = (rd_ptr == commit_ptr);
    wr_accept = bus.write_enable & ~full & ~bus.write_drop;
    lost      = bus.write_enable & full & ~bus.write_drop;
    // A last word arriving while full truncates the packet just like a
    // word lost earlier, so it rewinds too.
    rewind    = bus.write_drop |
                (bus.write_enable & bus.write_last & (overflow | full));
    commit    = wr_accept & bus.write_last & ~overflow;
    rd_accept = bus.read_enable & ~empty;
    pkt_dec   = rd_accept & rd_is_last;
  end

  // Pointer, packet counter and overflow state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      rd_ptr         <= '0;
      packet_count_q <= '0;
      overflow       <= 1'b0;
      read_valid_q   <= 1'b0;
    end else begin
      if (rewind)         wr_ptr <= commit_ptr;
      else if (wr_accept) wr_ptr <= wr_ptr + 1'b1;

      if (commit)    commit_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr     <= rd_ptr + 1'b1;

      if (rewind)    overflow <= 1'b0;
      else if (lost) overflow <= 1'b1;

      if (commit && !pkt_dec)      packet_count_q <= packet_count_q + 1'b1;
      else if (!commit && pkt_dec) packet_count_q <= packet_count_q - 1'b1;

      read_valid_q <= rd_accept;
    end
  end

  packet_fifo_ram #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_accept),
    .wr_addr   (wr_ptr[AW-1:0]),
    .wr_data   ({bus.write_last, bus.write_data}),
    .rd_en     (rd_accept),
    .rd_addr   (rd_ptr[AW-1:0]),
    .rd_data   (rd_word),
    .peek_last (rd_is_last)
  );

  assign bus.read_data    = rd_word[WIDTH-1:0];
  assign bus.read_last    = rd_word[WIDTH];
  assign bus.read_valid   = read_valid_q;
  assign bus.is_empty     = empty;
  assign bus.is_full      = full;
  assign bus.almost_full  = ((DEPTH_W - fill) <= MARGIN_W);
  assign bus.fill_level   = fill;
  assign bus.packet_count = packet_count_q;

`ifdef PACKET_FIFO_STATS_EN
  // Saturating count of rewinds that discarded words; sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count    <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (rewind && (wr_ptr != commit_ptr) && (drop_count != '1))
        drop_count <= drop_count + STAT_COUNT_WIDTH'(1);
      if (lost) overflow_seen <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_fifo.sv
// ---------------------------------------------------------------------------
// tb_packet_fifo
// Directed self-checking bench for packet_fifo (WIDTH=8, DEPTH=8, MARGIN=2).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_packet_fifo;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  logic [8:0] sb[$];     // committed words awaiting read, {last,data}
  logic [8:0] pend[$];   // words of the packet being written

  packet_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

`ifdef PACKET_FIFO_STATS_EN
  logic [15:0] drop_count;
  logic        overflow_seen;
`endif

  packet_fifo #(
    .WIDTH              (8),
    .DEPTH              (8),
    .ALMOST_FULL_MARGIN (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef PACKET_FIFO_STATS_EN
    ,
    .drop_count    (drop_count),
    .overflow_seen (overflow_seen)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic l);
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    bus.write_last   = l;
    step();
    bus.write_enable = 1'b0;
    bus.write_last   = 1'b0;
    pend.push_back({l, d});
    if (l) begin
      while (pend.size() > 0) sb.push_back(pend.pop_front());
    end
  endtask

  task automatic check_read_out(input string tag);
    logic [8:0] e;
    chk({tag, "_valid"}, 32'(bus.read_valid), 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=read expected=no_data", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(bus.read_data), 32'(e[7:0]));
      chk({tag, "_last"}, 32'(bus.read_last), 32'(e[8]));
    end
  endtask

  task automatic do_read(input string tag);
    bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    check_read_out(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.write_data   = '0;
    bus.write_enable = 1'b0;
    bus.write_last   = 1'b0;
    bus.write_drop   = 1'b0;
    bus.read_enable  = 1'b0;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // 1: reset state and read while empty
    chk("rst_empty", 32'(bus.is_empty), 32'd1);
    chk("rst_full", 32'(bus.is_full), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk("rst_fill", 32'(bus.fill_level), 32'd0);
    chk("rst_pcount", 32'(bus.packet_count), 32'd0);
    chk("rst_rdata", 32'(bus.read_data), 32'd0);
`ifdef PACKET_FIFO_STATS_EN
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow_seen), 32'd0);
`endif
    bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t1_rvalid", 32'(bus.read_valid), 32'd0);
    chk("t1_empty", 32'(bus.is_empty), 32'd1);
    chk("t1_pcount", 32'(bus.packet_count), 32'd0);

    // 2: one three-word packet
    do_write(8'h11, 1'b0);
    chk("t2_empty1", 32'(bus.is_empty), 32'd1);
    do_write(8'h22, 1'b0);
    chk("t2_empty2", 32'(bus.is_empty), 32'd1);
    chk("t2_fill2", 32'(bus.fill_level), 32'd2);
    do_write(8'h33, 1'b1);
    chk("t2_empty3", 32'(bus.is_empty), 32'd0);
    chk("t2_pcount1", 32'(bus.packet_count), 32'd1);
    do_read("t2_r0");
    do_read("t2_r1");
    do_read("t2_r2");
    chk("t2_pcount0", 32'(bus.packet_count), 32'd0);
    chk("t2_empty_end", 32'(bus.is_empty), 32'd1);

    // 3: drop of an in-flight packet behind a committed one
    do_write(8'hA0, 1'b1);
    do_write(8'hB0, 1'b0);
    do_write(8'hB1, 1'b0);
    chk("t3_fill3", 32'(bus.fill_level), 32'd3);
    bus.write_drop = 1'b1;
    step();
    bus.write_drop = 1'b0;
    pend.delete();
    chk("t3_fill1", 32'(bus.fill_level), 32'd1);
    chk("t3_pcount", 32'(bus.packet_count), 32'd1);
    do_read("t3_r0");
    chk("t3_empty", 32'(bus.is_empty), 32'd1);
`ifdef PACKET_FIFO_STATS_EN
    chk("t3_drops", 32'(drop_count), 32'd1);
    bus.write_drop = 1'b1;
    step();
    bus.write_drop = 1'b0;
    chk("t3_drop_noop", 32'(drop_count), 32'd1);
`endif

    // 4: overflow, lost last word, rewind
    for (int i = 1; i <= 9; i++) begin
      do_write(8'(i), (i == 9));
      if (i == 5) chk("t4_afull5", 32'(bus.almost_full), 32'd0);
      if (i == 6) chk("t4_afull6", 32'(bus.almost_full), 32'd1);
      if (i == 7) chk("t4_full7", 32'(bus.is_full), 32'd0);
      if (i == 8) chk("t4_full8", 32'(bus.is_full), 32'd1);
      if (i == 8) chk("t4_empty8", 32'(bus.is_empty), 32'd1);
    end
    sb.delete();
    pend.delete();
    chk("t4_fill", 32'(bus.fill_level), 32'd0);
    chk("t4_pcount", 32'(bus.packet_count), 32'd0);
    chk("t4_empty", 32'(bus.is_empty), 32'd1);
    chk("t4_full_after", 32'(bus.is_full), 32'd0);
`ifdef PACKET_FIFO_STATS_EN
    chk("t4_ovf", 32'(overflow_seen), 32'd1);
    chk("t4_drops", 32'(drop_count), 32'd2);
`endif

    // 5: commit and read of a last word in the same cycle
    do_write(8'h51, 1'b1);
    do_write(8'h61, 1'b0);
    chk("t5_pcount_pre", 32'(bus.packet_count), 32'd1);
    bus.write_data   = 8'h62;
    bus.write_enable = 1'b1;
    bus.write_last   = 1'b1;
    bus.read_enable  = 1'b1;
    step();
    bus.write_enable = 1'b0;
    bus.write_last   = 1'b0;
    bus.read_enable  = 1'b0;
    check_read_out("t5_rA");
    pend.push_back({1'b1, 8'h62});
    while (pend.size() > 0) sb.push_back(pend.pop_front());
    chk("t5_pcount_same", 32'(bus.packet_count), 32'd1);
    do_read("t5_rB0");
    do_read("t5_rB1");
    chk("t5_pcount_end", 32'(bus.packet_count), 32'd0);

    // 6: asynchronous reset mid-packet
    do_write(8'h71, 1'b0);
    do_write(8'h72, 1'b1);
    do_write(8'h73, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_empty_async", 32'(bus.is_empty), 32'd1);
    chk("t6_fill_async", 32'(bus.fill_level), 32'd0);
    chk("t6_pcount_async", 32'(bus.packet_count), 32'd0);
    sb.delete();
    pend.delete();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    do_write(8'h81, 1'b0);
    do_write(8'h82, 1'b1);
    chk("t6_pcount", 32'(bus.packet_count), 32'd1);
    do_read("t6_r0");
    do_read("t6_r1");
    chk("t6_empty_end", 32'(bus.is_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
